// File: rtl/io_axil_responder_if.sv
// AXI4-Lite slave-side channel bundle for io_axil_responder.
interface io_axil_responder_if;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;

    modport master (
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
    );

    modport slave (
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
    );
endinterface

// File: rtl/io_axil_responder.sv
// AXI4-Lite register window: SCRATCH, GPIO_OUT, synchronized GPIO_IN and a free-running CYCLE counter.
// Reads pass through a wait-state FSM; writes are single-beat with AW and W accepted together.
module io_axil_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    io_axil_responder_if.slave axi,
    input  logic [31:0]        gpio_in,
    output logic [31:0]        gpio_out
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] WAIT_LOAD   = 4'(READ_WAIT);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    rd_state_t   state_r;
    rd_state_t   state_nxt_s;
    logic [3:0]  wait_cnt_r;
    logic [31:0] araddr_r;
    logic        arready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] scratch_r;
    logic [31:0] gpio_out_r;
    logic [31:0] sync1_r;
    logic [31:0] sync2_r;
    logic [31:0] cycle_r;
    logic        ar_take_s;
    logic        wr_take_s;
    logic [31:0] rd_addr_s;
    logic [31:0] rd_data_s;
    logic [1:0]  rd_resp_s;

    function automatic logic addr_hit(input logic [31:0] addr);
        return (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Read FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        ar_take_s   = 1'b0;
        case (state_r)
            R_IDLE: begin
                if (axi.s_axi_arvalid && arready_r) begin
                    ar_take_s   = 1'b1;
                    state_nxt_s = (WAIT_LOAD != 4'd0) ? R_WAIT : R_RESP;
                end else begin
                    state_nxt_s = R_IDLE;
                end
            end
            R_WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    state_nxt_s = R_RESP;
                end else begin
                    state_nxt_s = R_WAIT;
                end
            end
            R_RESP: begin
                if (axi.s_axi_rready) begin
                    state_nxt_s = R_IDLE;
                end else begin
                    state_nxt_s = R_RESP;
                end
            end
            default: state_nxt_s = R_IDLE;
        endcase
    end

    // Read decode; with no wait states the address is still on the bus when data is captured.
    always_comb begin
        rd_addr_s = (state_r == R_IDLE) ? axi.s_axi_araddr : araddr_r;
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_SLVERR;
        if (addr_hit(rd_addr_s)) begin
            rd_resp_s = RESP_OKAY;
            case (rd_addr_s[3:2])
                2'd0:    rd_data_s = scratch_r;
                2'd1:    rd_data_s = gpio_out_r;
                2'd2:    rd_data_s = sync2_r;
                2'd3:    rd_data_s = cycle_r;
                default: rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_resp_s = RESP_SLVERR;
            rd_data_s = 32'h0000_0000;
        end
    end

    // Read channel state, wait counter and captured response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= R_IDLE;
            wait_cnt_r <= 4'd0;
            araddr_r   <= 32'h0000_0000;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            rresp_r    <= RESP_OKAY;
        end else begin
            state_r   <= state_nxt_s;
            arready_r <= (state_nxt_s == R_IDLE);
            rvalid_r  <= (state_nxt_s == R_RESP);
            if (ar_take_s) begin
                araddr_r   <= axi.s_axi_araddr;
                wait_cnt_r <= WAIT_LOAD;
            end else if (state_r == R_WAIT) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
            if ((state_nxt_s == R_RESP) && (state_r != R_RESP)) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

    assign wr_take_s = rst && axi.s_axi_awvalid && axi.s_axi_wvalid && !bvalid_r;

    // Write commit and write-response channel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scratch_r  <= 32'h0000_0000;
            gpio_out_r <= 32'h0000_0000;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
        end else if (wr_take_s) begin
            bvalid_r <= 1'b1;
            if (addr_hit(axi.s_axi_awaddr) && !axi.s_axi_awaddr[3]) begin
                bresp_r <= RESP_OKAY;
                if (!axi.s_axi_awaddr[2]) begin
                    scratch_r <= merge_lanes(scratch_r, axi.s_axi_wdata, axi.s_axi_wstrb);
                end else begin
                    gpio_out_r <= merge_lanes(gpio_out_r, axi.s_axi_wdata, axi.s_axi_wstrb);
                end
            end else begin
                bresp_r <= RESP_SLVERR;
            end
        end else if (bvalid_r && axi.s_axi_bready) begin
            bvalid_r <= 1'b0;
        end
    end

    // Free-running cycle counter and two-flop gpio_in synchronizer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_r <= 32'h0000_0000;
            sync1_r <= 32'h0000_0000;
            sync2_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_r + 32'd1;
            sync1_r <= gpio_in;
            sync2_r <= sync1_r;
        end
    end

    assign axi.s_axi_arready = arready_r;
    assign axi.s_axi_rdata   = rdata_r;
    assign axi.s_axi_rresp   = rresp_r;
    assign axi.s_axi_rvalid  = rvalid_r;
    assign axi.s_axi_awready = wr_take_s;
    assign axi.s_axi_wready  = wr_take_s;
    assign axi.s_axi_bresp   = bresp_r;
    assign axi.s_axi_bvalid  = bvalid_r;
    assign gpio_out          = gpio_out_r;
endmodule

// File: tb/tb_io_axil_responder.sv
// Self-checking bench for io_axil_responder: vector table, corner-case sequences and a
// randomized run against a register-map reference model.
module tb_io_axil_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_out3;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned edges = 0;
    logic [31:0] tb_cyc = 32'd0;

    io_axil_responder_if a();
    io_axil_responder_if b();

    io_axil_responder #(.BASE_ADDR(32'h8000_0000), .READ_WAIT(1)) dut (
        .clk(clk), .rst(rst), .axi(a), .gpio_in(gpio_in), .gpio_out(gpio_out));

    io_axil_responder #(.BASE_ADDR(32'h8000_0000), .READ_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .axi(b), .gpio_in(gpio_in), .gpio_out(gpio_out3));

    always #5 clk = ~clk;

    // Spec-level cycle model: zero at a reset edge, +1 on every other edge.
    always @(posedge clk) begin
        edges  <= edges + 1;
        tb_cyc <= rst ? tb_cyc + 32'd1 : 32'd0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic hit(input logic [31:0] ad);
        return (ad[31:4] == BASE[31:4]) && (ad[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic do_write(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        @(negedge clk);
        a.s_axi_awaddr  = ad;
        a.s_axi_wdata   = d;
        a.s_axi_wstrb   = s;
        a.s_axi_awvalid = 1'b1;
        a.s_axi_wvalid  = 1'b1;
        #1;
        n = 0;
        while (!a.s_axi_awready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk1("w_accept", a.s_axi_awready && a.s_axi_wready, 1'b1);
        @(negedge clk);
        a.s_axi_awvalid = 1'b0;
        a.s_axi_wvalid  = 1'b0;
        chk1("bvalid_rise", a.s_axi_bvalid, 1'b1);
        resp = a.s_axi_bresp;
        a.s_axi_bready = 1'b1;
        @(negedge clk);
        a.s_axi_bready = 1'b0;
        chk1("bvalid_clear", a.s_axi_bvalid, 1'b0);
    endtask

    // Returns data/resp, handshake-to-rvalid latency, edge stamp and expected CYCLE value.
    task automatic do_read(input logic [31:0] ad, input int stall, output logic [31:0] d,
                           output logic [1:0] resp, output int lat, output int unsigned cap,
                           output logic [31:0] cexp);
        int n;
        @(negedge clk);
        a.s_axi_araddr  = ad;
        a.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!a.s_axi_arready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk1("ar_accept", a.s_axi_arready, 1'b1);
        @(negedge clk);
        a.s_axi_arvalid = 1'b0;
        lat = 1;
        while (!a.s_axi_rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk1("rvalid_seen", a.s_axi_rvalid, 1'b1);
        cap  = edges;
        cexp = tb_cyc - 32'd1;
        d    = a.s_axi_rdata;
        resp = a.s_axi_rresp;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("rdata_hold", a.s_axi_rdata, d);
        end
        a.s_axi_rready = 1'b1;
        @(negedge clk);
        a.s_axi_rready = 1'b0;
        chk1("rvalid_clear", a.s_axi_rvalid, 1'b0);
    endtask

    initial begin
        vec_t        vecs[19];
        logic [31:0] d, ad, cexp, m_scr, m_gpo, m_gin, v0, exp_d;
        logic [31:0] wv[6];
        int unsigned wc[6];
        int unsigned cap;
        logic [1:0]  r, exp_r;
        logic [2:0]  sel;
        logic [3:0]  s;
        int          lat, n;
        bit          seen;

        vecs[0]  = '{1'b1, 32'h8000_0000, 32'hA5A5_0F0F, 4'hF, 2'b00, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'hA5A5_0F0F, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF, 2'b00, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h2, 2'b00, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 2'b00, 32'h1234_FF78, 1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b10, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 2'b10, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h8000_000C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h8000_000C, 32'h0,         4'h0, 2'b00, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 32'h8000_0008, 32'h0,         4'hF, 2'b10, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'h0, 2'b00, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'hA5A5_0F0F, 1'b0};
        vecs[12] = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'h9, 2'b00, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'h11A5_0F44, 1'b0};
        vecs[14] = '{1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0, 1'b0};
        vecs[15] = '{1'b1, 32'h8000_0005, 32'h0,         4'hF, 2'b10, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 2'b00, 32'h1234_FF78, 1'b0};
        vecs[17] = '{1'b0, 32'h7FFF_FFF0, 32'h0,         4'h0, 2'b10, 32'h0, 1'b0};
        vecs[18] = '{1'b0, 32'h8000_0008, 32'h0,         4'h0, 2'b00, 32'hCAFE_0001, 1'b0};

        rst = 1'b0;
        gpio_in = 32'hCAFE_0001;
        a.s_axi_araddr = BASE; a.s_axi_arvalid = 1'b1; a.s_axi_rready = 1'b0;
        a.s_axi_awaddr = BASE; a.s_axi_awvalid = 1'b1; a.s_axi_wdata = 32'h1;
        a.s_axi_wstrb = 4'hF;  a.s_axi_wvalid = 1'b1;  a.s_axi_bready = 1'b0;
        b.s_axi_araddr = 32'h0; b.s_axi_arvalid = 1'b0; b.s_axi_rready = 1'b0;
        b.s_axi_awaddr = 32'h0; b.s_axi_awvalid = 1'b0; b.s_axi_wdata = 32'h0;
        b.s_axi_wstrb = 4'h0;   b.s_axi_wvalid = 1'b0;  b.s_axi_bready = 1'b0;

        // Reset state, with request valids held high throughout.
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_arready", a.s_axi_arready, 1'b0);
        chk1("rst_awready", a.s_axi_awready, 1'b0);
        chk1("rst_wready", a.s_axi_wready, 1'b0);
        chk1("rst_rvalid", a.s_axi_rvalid, 1'b0);
        chk1("rst_bvalid", a.s_axi_bvalid, 1'b0);
        chk("rst_rdata", a.s_axi_rdata, 32'h0);
        chk("rst_rresp", {30'd0, a.s_axi_rresp}, 32'h0);
        chk("rst_bresp", {30'd0, a.s_axi_bresp}, 32'h0);
        chk("rst_gpio_out", gpio_out, 32'h0);
        a.s_axi_arvalid = 1'b0; a.s_axi_awvalid = 1'b0; a.s_axi_wvalid = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].resp});
            end else begin
                do_read(vecs[i].addr, 0, d, r, lat, cap, cexp);
                chk($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].resp});
                chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].cyc ? cexp : vecs[i].rdata);
            end
        end
        chk("table_gpio_out", gpio_out, 32'h1234_FF78);

        // A write committed on the read's capture edge must not be visible to that read.
        @(negedge clk);
        a.s_axi_araddr = BASE; a.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!a.s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        a.s_axi_arvalid = 1'b0;
        a.s_axi_awaddr = BASE; a.s_axi_wdata = 32'h0BAD_F00D; a.s_axi_wstrb = 4'hF;
        a.s_axi_awvalid = 1'b1; a.s_axi_wvalid = 1'b1;
        #1;
        chk1("same_edge_awready", a.s_axi_awready, 1'b1);
        @(negedge clk);
        a.s_axi_awvalid = 1'b0; a.s_axi_wvalid = 1'b0;
        chk1("same_edge_rvalid", a.s_axi_rvalid, 1'b1);
        chk("same_edge_old_data", a.s_axi_rdata, 32'h11A5_0F44);
        a.s_axi_rready = 1'b1; a.s_axi_bready = 1'b1;
        @(negedge clk);
        a.s_axi_rready = 1'b0; a.s_axi_bready = 1'b0;
        do_read(BASE, 0, d, r, lat, cap, cexp);
        chk("same_edge_new_data", d, 32'h0BAD_F00D);

        // GPIO_IN read stalled by rready=0 while gpio_in toggles.
        gpio_in = 32'h5A5A_1234;
        repeat (3) @(negedge clk);
        a.s_axi_araddr = BASE + 32'h8; a.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!a.s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        a.s_axi_arvalid = 1'b0;
        n = 0;
        while (!a.s_axi_rvalid && n < 40) begin @(negedge clk); n++; end
        chk("stall_gpio_data", a.s_axi_rdata, 32'h5A5A_1234);
        for (int k = 0; k < 5; k++) begin
            gpio_in = ~gpio_in;
            @(negedge clk);
            chk("stall_rdata", a.s_axi_rdata, 32'h5A5A_1234);
            chk1("stall_arready", a.s_axi_arready, 1'b0);
            chk1("stall_rvalid", a.s_axi_rvalid, 1'b1);
        end
        a.s_axi_rready = 1'b1;
        @(negedge clk);
        a.s_axi_rready = 1'b0;

        // Randomized traffic against the register-map model.
        m_scr = 32'h0BAD_F00D;
        m_gpo = 32'h1234_FF78;
        m_gin = gpio_in;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                gpio_in = $urandom;
                m_gin = gpio_in;
                repeat (3) @(negedge clk);
            end
            sel = 3'($urandom_range(0, 7));
            case (sel)
                3'd4:    ad = BASE | {26'd0, 4'($urandom_range(0, 3) * 4 + $urandom_range(1, 3))};
                3'd5:    ad = $urandom;
                default: ad = BASE | {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            endcase
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(ad, d, s, r);
                if (hit(ad) && !ad[3]) begin
                    exp_r = 2'b00;
                    if (ad[2]) m_gpo = lane_merge(m_gpo, d, s);
                    else m_scr = lane_merge(m_scr, d, s);
                end else begin
                    exp_r = 2'b10;
                end
                chk($sformatf("rnd%0d_bresp", i), {30'd0, r}, {30'd0, exp_r});
                chk($sformatf("rnd%0d_gpio_out", i), gpio_out, m_gpo);
            end else begin
                do_read(ad, $urandom_range(0, 3), d, r, lat, cap, cexp);
                exp_r = hit(ad) ? 2'b00 : 2'b10;
                exp_d = 32'h0;
                if (hit(ad)) begin
                    case (ad[3:2])
                        2'd0:    exp_d = m_scr;
                        2'd1:    exp_d = m_gpo;
                        2'd2:    exp_d = m_gin;
                        default: exp_d = cexp;
                    endcase
                end
                chk($sformatf("rnd%0d_rresp", i), {30'd0, r}, {30'd0, exp_r});
                chk($sformatf("rnd%0d_rdata", i), d, exp_d);
                chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
            end
        end

        // Three wait states: first rvalid four cycles after the AR handshake.
        @(negedge clk);
        b.s_axi_araddr = BASE; b.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!b.s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        b.s_axi_arvalid = 1'b0;
        lat = 1;
        while (!b.s_axi_rvalid && lat < 40) begin @(negedge clk); lat++; end
        chk("rw3_lat", 32'(lat), 32'd4);
        chk("rw3_rdata", b.s_axi_rdata, 32'h0);
        chk("rw3_rresp", {30'd0, b.s_axi_rresp}, 32'h0);
        b.s_axi_rready = 1'b1;
        @(negedge clk);
        b.s_axi_rready = 1'b0;

        // CYCLE wrap: preload near the top, then successive reads must cross zero.
        @(negedge clk);
        force dut.cycle_r = 32'hFFFF_FFF0;
        @(posedge clk);
        #1;
        release dut.cycle_r;
        for (int k = 0; k < 6; k++) begin
            do_read(BASE + 32'hC, 0, wv[k], r, lat, wc[k], cexp);
            chk($sformatf("wrap%0d_rresp", k), {30'd0, r}, 32'h0);
        end
        v0 = wv[0];
        chk("wrap_start_high", {8'd0, v0[31:8]}, 32'h00FF_FFFF);
        v0 = wv[5];
        chk("wrap_end_low", {8'd0, v0[31:8]}, 32'h0);
        for (int k = 1; k < 6; k++) begin
            chk($sformatf("wrap%0d_step", k), wv[k] - wv[k-1], wc[k] - wc[k-1]);
        end

        // Reset during R_WAIT with a write response pending.
        do_write(BASE, 32'h5555_AAAA, 4'hF, r);
        @(negedge clk);
        a.s_axi_awaddr = BASE + 32'h4; a.s_axi_wdata = 32'hFFFF_0000; a.s_axi_wstrb = 4'hF;
        a.s_axi_awvalid = 1'b1; a.s_axi_wvalid = 1'b1;
        a.s_axi_araddr = BASE; a.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!(a.s_axi_arready && a.s_axi_awready) && n < 20) begin @(negedge clk); #1; n++; end
        chk1("rm_both_ready", a.s_axi_arready && a.s_axi_awready, 1'b1);
        @(negedge clk);
        a.s_axi_awvalid = 1'b0; a.s_axi_wvalid = 1'b0; a.s_axi_arvalid = 1'b0;
        chk1("rm_bvalid_pending", a.s_axi_bvalid, 1'b1);
        chk1("rm_in_wait", a.s_axi_rvalid, 1'b0);
        chk("rm_gpio_written", gpio_out, 32'hFFFF_0000);
        rst = 1'b0;
        @(negedge clk);
        chk1("rm_rvalid", a.s_axi_rvalid, 1'b0);
        chk1("rm_bvalid", a.s_axi_bvalid, 1'b0);
        chk("rm_gpio_out", gpio_out, 32'h0);
        chk1("rm_arready", a.s_axi_arready, 1'b0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (a.s_axi_rvalid || a.s_axi_bvalid) seen = 1'b1;
        end
        chk1("rm_no_stale_resp", seen, 1'b0);
        do_read(BASE, 0, d, r, lat, cap, cexp);
        chk("rm_scratch_cleared", d, 32'h0);
        chk("rm_scratch_rresp", {30'd0, r}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/io_axil_responder.md
IO_AXIL_RESPONDER -- requirements
Module: io_axil_responder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h8000_0000, 16-byte-aligned base of the register window.
REQ-002 Parameter: READ_WAIT, 1, wait-state cycles between AR acceptance and R valid; legal range 0..15.
REQ-003 Port: clk  in  1  sole clock; all logic rising-edge.
REQ-004 Port: rst  in  1  synchronous, active-low reset.
REQ-005 Ports: s_axi_araddr in 32; s_axi_arvalid in 1; s_axi_arready out 1  (AXI4-Lite read-address channel).
REQ-006 Ports: s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1  (read-data channel).
REQ-007 Ports: s_axi_awaddr in 32; s_axi_awvalid in 1; s_axi_awready out 1; s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-008 Ports: s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1  (write-response channel).
REQ-009 Ports: gpio_in in 32 asynchronous input; gpio_out out 32 register-driven output.

Function
REQ-010 Register map (offset): 0x0 SCRATCH RW; 0x4 GPIO_OUT RW, drives gpio_out; 0x8 GPIO_IN RO; 0xC CYCLE RO.
REQ-011 Hit: addr[31:4]==BASE_ADDR[31:4] and addr[1:0]==0; otherwise response SLVERR (2'b10), rdata 0, no state change.
REQ-012 GPIO_IN: gpio_in passed through a two-flop synchronizer; a read returns the second-stage value.
REQ-013 CYCLE: free-running 32-bit counter, +1 every cycle, wraps 32'hFFFF_FFFF -> 0; not writable.
REQ-014 Read FSM states: R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE.
REQ-015 R_IDLE & arvalid: latch araddr, load wait counter with READ_WAIT; go R_WAIT if READ_WAIT>0, else R_RESP.
REQ-016 R_WAIT: decrement counter each cycle; on the cycle the counter reaches 1, go R_RESP.
REQ-017 rdata/rresp captured on the clock edge entering R_RESP and held stable while rvalid=1.
REQ-018 R_RESP: rvalid=1 until rready; on rvalid&rready return to R_IDLE (next AR accepted no earlier than the following cycle).
REQ-019 Read-to-response latency = READ_WAIT+1 cycles from AR handshake to first rvalid.
REQ-020 Write: awready=wready=1 in the same cycle only when awvalid&wvalid&!bvalid; AW and W are always accepted together.
REQ-021 On write handshake: commit to SCRATCH/GPIO_OUT that same edge, byte lanes per wstrb; wstrb=0 is OKAY with no change.
REQ-022 Write to GPIO_IN, CYCLE or a miss: SLVERR, no effect.
REQ-023 bvalid rises the cycle after the handshake, holds bresp until bready, then clears.
REQ-024 Read and write paths are independent; a write committed on the edge that captures rdata is not visible to that read (old value returned).
REQ-025 rresp/bresp OKAY = 2'b00; only OKAY and SLVERR are ever generated.

Reset
REQ-026 rst=0 at a clock edge: FSM to R_IDLE; rvalid, bvalid, rdata, rresp, bresp, SCRATCH, GPIO_OUT, CYCLE, synchronizer all 0.
REQ-027 Reset mid-transaction aborts it; no response for an aborted request is ever issued.
REQ-028 During reset, arready, awready and wready are 0.

Verification
REQ-029 READ_WAIT=1: write 32'hA5A5_0F0F to 0x8000_0000 (wstrb F) -> bresp 00; read -> rvalid 2 cycles after AR, rdata A5A5_0F0F, rresp 00.
REQ-030 Write GPIO_OUT 32'h1234_5678 then 32'hFFFF_FFFF with wstrb 4'b0010 -> gpio_out = 32'h1234_FF78.
REQ-031 Read 0x8000_0010 or 0x8000_0002 -> rresp 10, rdata 0; write 0x8000_000C -> bresp 10, CYCLE unaffected.
REQ-032 Hold rready=0 for 5 cycles with a GPIO_IN read pending while gpio_in toggles -> rdata stable, arready stays 0.
REQ-033 Force CYCLE near wrap (read at 2^32-1 cycles elided via counter load hook or long sim) -> successive reads wrap to small values, no SLVERR.
REQ-034 Assert rst=0 during R_WAIT and with bvalid pending -> next cycle rvalid=bvalid=0, gpio_out=0; next read of SCRATCH returns 0.
